updown_cnt_checker: RTL and testbench
=====================================

// Module: updown_cnt_checker
// PURPOSE
//  Synthesizable reader/checker for the up/down counter interface: samples en/up_down
//  (stimulus) and cnt/overflow (DUT response) each clk, predicts expected counter state
//  independently, flags mismatches and counts errors. Lives on the monitor side of the
//  DV environment; also usable as an in-silicon assertion block.
// PARAMETERS
//  WIDTH        4  counter width; cnt wraps modulo 2**WIDTH
//  ERR_W        8  error counter width; saturates at 2**ERR_W-1
//  STOP_ON_ERR  0  1: freeze in HALT on first mismatch; 0: log and continue
// PORTS
//  clk        in   1        clock; all sampling on posedge
//  rst        in   1        asynchronous, active-high reset
//  chk_en     in   1        1 = checking enabled
//  clr_err    in   1        sync clear of err_cnt/halted; returns FSM to IDLE
//  en         in   1        observed DUT count enable
//  up_down    in   1        observed direction: 1 = up, 0 = down
//  cnt        in   WIDTH    observed DUT count
//  overflow   in   1        observed DUT wrap flag
//  exp_cnt    out  WIDTH    predicted count for current cycle
//  exp_ovf    out  1        predicted wrap flag for current cycle
//  mismatch   out  1        1-cycle pulse: compare failed on previous edge
//  err_cnt    out  ERR_W    saturating mismatch count
//  halted     out  1        1 while in HALT (STOP_ON_ERR=1 only)
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE; exp_cnt=0, exp_ovf=0, mismatch=0, err_cnt=0, halted=0.
//  DUT model: at posedge, en=0 -> cnt holds, ovf=0; en=1,up -> cnt+1 mod 2**WIDTH, ovf=1 iff
//   old cnt==max; en=1,down -> cnt-1 mod 2**WIDTH, ovf=1 iff old cnt==0. ovf lasts 1 cycle.
//  next(x) = the model above applied to value x with sampled en/up_down.
//  FSM states: IDLE, SYNC, CHECK, HALT.
//   IDLE : chk_en=1 -> SYNC. No compares, mismatch=0.
//   SYNC : exp_cnt<=next(cnt), exp_ovf<=model ovf -> CHECK (one edge, seeds predictor).
//   CHECK: compare {overflow,cnt} vs {exp_ovf,exp_cnt}.
//     equal   -> exp <= next(exp_cnt); stay.
//     differ  -> mismatch<=1 next cycle; err_cnt+1 (saturating); exp re-seeded from
//                next(observed cnt) so one fault = one error; STOP_ON_ERR=1 -> HALT.
//   HALT : halted=1; exp_*, err_cnt frozen; leave only via clr_err or rst.
//  Latency: DUT value wrong in cycle N -> mismatch high in cycle N+1, exactly 1 cycle.
//  chk_en=0 in IDLE/SYNC/CHECK -> IDLE next edge; err_cnt retained. HALT ignores chk_en.
//  clr_err (any state): err_cnt<=0, halted<=0, mismatch<=0, FSM<=IDLE; wins over a
//   simultaneous mismatch (that error not counted).
//  err_cnt at max stays max; mismatch still pulses.
//  Arithmetic: all predictor math WIDTH bits, wrap by truncation; no X propagation
//   from exp_* (always driven from flops).
// CONFIGURATION
//  CNT_CHK_CAPTURE_EN defined: adds outputs first_obs[WIDTH+1], first_exp[WIDTH+1]
//   ({ovf,cnt}) plus first_vld[1]; loaded on first mismatch after reset/clr_err, held
//   until rst/clr_err (reset value 0). Later mismatches do not overwrite.
//  Not defined: those ports and flops absent; all other behaviour identical.
// TESTING
//  1 Clean up-count: rst, chk_en=1, correct DUT, en=1 up=1, 20 cycles from cnt=0 ->
//    mismatch never 1, err_cnt=0, exp_ovf=1 exactly in cycle exp_cnt 15->0 (WIDTH=4).
//  2 Down wrap: cnt=0, en=1 up_down=0 -> exp_cnt=15, exp_ovf=1 next cycle; no mismatch.
//  3 Value fault: force cnt=5 where exp_cnt=4 -> mismatch 1 for one cycle, err_cnt=1,
//    following cycles clean with predictor re-seeded (from 5), err_cnt stays 1.
//  4 Missing overflow: DUT wraps 15->0 with overflow=0 -> one mismatch, err_cnt=1.
//  5 STOP_ON_ERR=1: fault as 3 -> halted=1, exp_cnt frozen, chk_en toggles ignored;
//    clr_err=1 -> halted=0, err_cnt=0, FSM IDLE; re-enable -> SYNC -> CHECK clean.
//  6 Async rst mid-CHECK (err_cnt=3) -> all outputs 0 same cycle, before next posedge;
//    with CNT_CHK_CAPTURE_EN, first_vld=0 and capture fields 0.

Source files
------------

// File: rtl/updown_cnt_checker.sv
// Monitor-side checker for an up/down counter: predicts cnt/overflow, flags and counts mismatches.
// Optional first-mismatch capture registers are enabled by defining CNT_CHK_CAPTURE_EN.
module updown_cnt_checker #(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chk_en,
  input  logic             clr_err,
  input  logic             en,
  input  logic             up_down,
  input  logic [WIDTH-1:0] cnt,
  input  logic             overflow,
  output logic [WIDTH-1:0] exp_cnt,
  output logic             exp_ovf,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             halted
`ifdef CNT_CHK_CAPTURE_EN
  ,
  output logic [WIDTH:0]   first_obs,
  output logic [WIDTH:0]   first_exp,
  output logic             first_vld
`endif
);

  // state | meaning
  // IDLE  | checking off, predictor holds
  // SYNC  | seed predictor from observed cnt on next edge
  // CHECK | compare observed vs predicted every edge
  // HALT  | stopped on first mismatch, everything frozen until clr_err
  typedef enum logic [1:0] {IDLE, SYNC, CHECK, HALT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   exp_nxt;
  logic [WIDTH:0]   seed_obs;
  logic [WIDTH:0]   seed_exp;
  logic [WIDTH:0]   obs;
  logic             mis_nxt;
  logic             err_inc;

  // Returns {ovf, cnt} after one edge of the reference counter starting at x.
  function automatic logic [WIDTH:0] model_step(input logic [WIDTH-1:0] x,
                                                input logic e, input logic ud);
    logic [WIDTH-1:0] one;
    logic [WIDTH:0]   res;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    if (!e)
      res = {1'b0, x};
    else if (ud)
      res = {(x == {WIDTH{1'b1}}), x + one};
    else
      res = {(x == {WIDTH{1'b0}}), x - one};
    return res;
  endfunction

  always_comb begin
    state_nxt = state;
    exp_nxt   = {exp_ovf, exp_cnt};
    mis_nxt   = 1'b0;
    err_inc   = 1'b0;
    obs       = {overflow, cnt};
    seed_obs  = model_step(cnt, en, up_down);
    seed_exp  = model_step(exp_cnt, en, up_down);
    if (clr_err) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (chk_en) state_nxt = SYNC;
        end
        SYNC: begin
          if (!chk_en) begin
            state_nxt = IDLE;
          end else begin
            exp_nxt   = seed_obs;
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          if (!chk_en) begin
            state_nxt = IDLE;
          end else if (obs == {exp_ovf, exp_cnt}) begin
            exp_nxt = seed_exp;
          end else begin
            // Re-seed from the observed value so a single fault counts once.
            mis_nxt = 1'b1;
            err_inc = 1'b1;
            exp_nxt = seed_obs;
            if (STOP_ON_ERR != 0) state_nxt = HALT;
          end
        end
        HALT: begin
          state_nxt = HALT;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_cnt  <= '0;
      exp_ovf  <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      {exp_ovf, exp_cnt} <= exp_nxt;
      mismatch           <= mis_nxt;
      if (clr_err)
        err_cnt <= '0;
      else if (err_inc && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
    end
  end

  assign halted = (state == HALT);

`ifdef CNT_CHK_CAPTURE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_obs <= '0;
      first_exp <= '0;
      first_vld <= 1'b0;
    end else if (clr_err) begin
      first_obs <= '0;
      first_exp <= '0;
      first_vld <= 1'b0;
    end else if (err_inc && !first_vld) begin
      first_obs <= obs;
      first_exp <= {exp_ovf, exp_cnt};
      first_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_updown_cnt_checker.sv
// Random + directed bench for updown_cnt_checker; one instance logs-and-continues, one halts on error.
// Reference model works on plain integers and is updated after every clock edge.
module tb_updown_cnt_checker;

  logic       clk = 1'b0;
  logic       rst, chk_en, clr_err, en, up_down, overflow;
  logic [3:0] cnt;
  logic [3:0] exp_cnt0, exp_cnt1;
  logic       exp_ovf0, exp_ovf1, mismatch0, mismatch1, halted0, halted1;
  logic [7:0] err_cnt0, err_cnt1;
`ifdef CNT_CHK_CAPTURE_EN
  logic [4:0] first_obs0, first_exp0, first_obs1, first_exp1;
  logic       first_vld0, first_vld1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // emulated counter DUT
  int dc, dovf;

  // reference model, index 0 = log-and-continue, 1 = stop-on-error
  int m_st[2], m_exp[2], m_eovf[2], m_mis[2], m_err[2];
  int m_fv[2], m_fo[2], m_fe[2];

  always #5 clk = ~clk;

  updown_cnt_checker #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(0)) u_dut0 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .en(en), .up_down(up_down),
    .cnt(cnt), .overflow(overflow), .exp_cnt(exp_cnt0), .exp_ovf(exp_ovf0),
    .mismatch(mismatch0), .err_cnt(err_cnt0), .halted(halted0)
`ifdef CNT_CHK_CAPTURE_EN
    , .first_obs(first_obs0), .first_exp(first_exp0), .first_vld(first_vld0)
`endif
  );

  updown_cnt_checker #(.WIDTH(4), .ERR_W(8), .STOP_ON_ERR(1)) u_dut1 (
    .clk(clk), .rst(rst), .chk_en(chk_en), .clr_err(clr_err), .en(en), .up_down(up_down),
    .cnt(cnt), .overflow(overflow), .exp_cnt(exp_cnt1), .exp_ovf(exp_ovf1),
    .mismatch(mismatch1), .err_cnt(err_cnt1), .halted(halted1)
`ifdef CNT_CHK_CAPTURE_EN
    , .first_obs(first_obs1), .first_exp(first_exp1), .first_vld(first_vld1)
`endif
  );

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void ref_next(input int x, input int e, input int ud,
                                   output int y, output int o);
    if (e == 0)       begin y = x;            o = 0;            end
    else if (ud != 0) begin y = (x + 1) % 16; o = (x == 15);    end
    else              begin y = (x + 15) % 16; o = (x == 0);    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_exp[i] = 0; m_eovf[i] = 0; m_mis[i] = 0; m_err[i] = 0;
      m_fv[i] = 0; m_fo[i] = 0; m_fe[i] = 0;
    end
  endfunction

  // model states: 0 idle, 1 sync, 2 check, 3 halt
  function automatic void model_edge(input int i, input int stop);
    int y, o;
    m_mis[i] = 0;
    if (clr_err) begin
      m_err[i] = 0; m_st[i] = 0; m_fv[i] = 0; m_fo[i] = 0; m_fe[i] = 0;
    end else if (m_st[i] == 0) begin
      if (chk_en) m_st[i] = 1;
    end else if (m_st[i] == 1) begin
      if (!chk_en) m_st[i] = 0;
      else begin
        ref_next(int'(cnt), int'(en), int'(up_down), y, o);
        m_exp[i] = y; m_eovf[i] = o; m_st[i] = 2;
      end
    end else if (m_st[i] == 2) begin
      if (!chk_en) m_st[i] = 0;
      else if (int'(cnt) == m_exp[i] && int'(overflow) == m_eovf[i]) begin
        ref_next(m_exp[i], int'(en), int'(up_down), y, o);
        m_exp[i] = y; m_eovf[i] = o;
      end else begin
        m_mis[i] = 1;
        if (m_err[i] < 255) m_err[i]++;
        if (!m_fv[i]) begin
          m_fv[i] = 1;
          m_fo[i] = int'(overflow) * 16 + int'(cnt);
          m_fe[i] = m_eovf[i] * 16 + m_exp[i];
        end
        ref_next(int'(cnt), int'(en), int'(up_down), y, o);
        m_exp[i] = y; m_eovf[i] = o;
        if (stop) m_st[i] = 3;
      end
    end
  endfunction

  task automatic check_all();
    chk_val("exp_cnt0",  int'(exp_cnt0),  m_exp[0]);
    chk_val("exp_ovf0",  int'(exp_ovf0),  m_eovf[0]);
    chk_val("mismatch0", int'(mismatch0), m_mis[0]);
    chk_val("err_cnt0",  int'(err_cnt0),  m_err[0]);
    chk_val("halted0",   int'(halted0),   0);
    chk_val("exp_cnt1",  int'(exp_cnt1),  m_exp[1]);
    chk_val("exp_ovf1",  int'(exp_ovf1),  m_eovf[1]);
    chk_val("mismatch1", int'(mismatch1), m_mis[1]);
    chk_val("err_cnt1",  int'(err_cnt1),  m_err[1]);
    chk_val("halted1",   int'(halted1),   int'(m_st[1] == 3));
`ifdef CNT_CHK_CAPTURE_EN
    chk_val("first_vld0", int'(first_vld0), m_fv[0]);
    chk_val("first_obs0", int'(first_obs0), m_fo[0]);
    chk_val("first_exp0", int'(first_exp0), m_fe[0]);
    chk_val("first_vld1", int'(first_vld1), m_fv[1]);
    chk_val("first_obs1", int'(first_obs1), m_fo[1]);
    chk_val("first_exp1", int'(first_exp1), m_fe[1]);
`endif
  endtask

  // one clock: drive, edge, update model and emulated counter, sample 1 time unit later
  task automatic cyc(input logic e, input logic ud, input logic ce, input logic cl);
    int y, o;
    en = e; up_down = ud; chk_en = ce; clr_err = cl;
    cnt = 4'(dc); overflow = (dovf != 0);
    @(posedge clk);
    model_edge(0, 0);
    model_edge(1, 1);
    ref_next(dc, int'(e), int'(ud), y, o);
    dc = y; dovf = o;
    #1;
    check_all();
  endtask

  initial begin
    int ovf_seen, held, guard;
    rst = 1'b1; chk_en = 0; clr_err = 0; en = 0; up_down = 0; cnt = 0; overflow = 0;
    dc = 0; dovf = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all();

    // clean up-count with one wrap
    ovf_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 1, 0);
      if (exp_ovf0) ovf_seen++;
    end
    chk_val("t1_ovf_count", ovf_seen, 1);
    chk_val("t1_err", int'(err_cnt0), 0);

    // down wrap through zero
    guard = 0;
    while (dc != 0 && guard < 20) begin cyc(1, 0, 1, 0); guard++; end
    cyc(1, 0, 1, 0);
    chk_val("t2_exp_cnt", int'(exp_cnt0), 15);
    chk_val("t2_exp_ovf", int'(exp_ovf0), 1);
    chk_val("t2_mismatch", int'(mismatch0), 0);

    // single value fault: observed 5 where 4 predicted
    guard = 0;
    while (!(dc == 4 && dovf == 0 && m_st[0] == 2 && m_exp[0] == 4) && guard < 40) begin
      cyc(1, 1, 1, 0); guard++;
    end
    chk_val("t3_reached", int'(guard < 40), 1);
    dc = 5;
    cyc(1, 1, 1, 0);
    chk_val("t3_mismatch", int'(mismatch0), 1);
    chk_val("t3_err", int'(err_cnt0), 1);
    chk_val("t3_exp_reseed", int'(exp_cnt0), 6);
    chk_val("t5_halted", int'(halted1), 1);
    held = int'(exp_cnt1);
    cyc(1, 1, 1, 0);
    chk_val("t3_pulse_1cyc", int'(mismatch0), 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, (k % 2) != 0, 0);
    chk_val("t5_exp_frozen", int'(exp_cnt1), held);
    chk_val("t5_still_halted", int'(halted1), 1);
    cyc(1, 1, 1, 1);
    chk_val("t5_clr_halted", int'(halted1), 0);
    chk_val("t5_clr_err", int'(err_cnt1), 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 1, 0);
    chk_val("t5_rechk_clean", int'(err_cnt1), 0);

    // missing overflow on 15 -> 0
    cyc(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 0);
    guard = 0;
    while (!(dc == 0 && dovf == 1) && guard < 40) begin cyc(1, 1, 1, 0); guard++; end
    dovf = 0;
    cyc(1, 1, 1, 0);
    chk_val("t4_mismatch", int'(mismatch0), 1);
    chk_val("t4_err", int'(err_cnt0), 1);

    // saturation: every cycle faulty
    for (int k = 0; k < 270; k++) begin
      dc = dc ^ 1;
      cyc(1, 1, 1, 0);
    end
    chk_val("sat_err", int'(err_cnt0), 255);
    chk_val("sat_pulse", int'(mismatch0), 1);

    // randomized traffic
    cyc(1, 1, 1, 1);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) dc = int'($urandom_range(0, 15));
        else dovf = (dovf == 0);
      end
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 40) == 0));
    end

    // async reset mid-check with three errors logged
    cyc(1, 1, 1, 1);
    for (int k = 0; k < 3; k++) cyc(1, 1, 1, 0);
    for (int f = 0; f < 3; f++) begin
      dc = (dc + 3) % 16;
      cyc(1, 1, 1, 0);
      cyc(1, 1, 1, 0);
    end
    chk_val("t6_err_before", int'(err_cnt0), 3);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);
    cyc(1, 1, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
